// File: rtl/team_06_i2c_sched_if.sv
// Bundle between the two requesters, the scheduler and the I2C byte engine.
// master = scheduler side, slave = requesters plus engine side.
interface team_06_i2c_sched_if;
  logic       req0, req1;
  logic [3:0] len0, len1;
  logic [7:0] rd_data0, rd_data1;
  logic       grant0, grant1;
  logic       done0, done1;
  logic       fail0, fail1;
  logic [3:0] rd_idx;
  logic       eng_start;
  logic [7:0] eng_byte;
  logic       eng_start_cond, eng_stop_cond;
  logic       eng_busy, eng_done, eng_ack;
  logic       busy;

  modport master (
    input  req0, req1, len0, len1, rd_data0, rd_data1, eng_busy, eng_done, eng_ack,
    output grant0, grant1, done0, done1, fail0, fail1, rd_idx,
           eng_start, eng_byte, eng_start_cond, eng_stop_cond, busy
  );
  modport slave (
    output req0, req1, len0, len1, rd_data0, rd_data1, eng_busy, eng_done, eng_ack,
    input  grant0, grant1, done0, done1, fail0, fail1, rd_idx,
           eng_start, eng_byte, eng_start_cond, eng_stop_cond, busy
  );
endinterface

// File: rtl/team_06_i2c_sched.sv
// Round-robin scheduler sharing one I2C byte engine between two write requesters,
// with per-transaction NACK retry and a fixed idle gap after every attempt.
module team_06_i2c_sched #(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  team_06_i2c_sched_if.master bus
);
  localparam int RW = (MAX_RETRY  > 1) ? $clog2(MAX_RETRY)  : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ADDR_ISSUE, ADDR_WAIT, DATA_ISSUE, DATA_WAIT, GAP} state_t;

  state_t          state;
  logic            ch, last_served, gap_retry;
  logic [3:0]      len, idx;
  logic [RW-1:0]   retry_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [1:0]      grant, done, fail;

  logic       pick, issue, in_data, last_byte;
  logic [7:0] rd_byte;

  // On a tie the channel not served last wins; otherwise whoever asks.
  assign pick      = (bus.req0 && bus.req1) ? ~last_served : bus.req1;
  assign issue     = (state == ADDR_ISSUE) || (state == DATA_ISSUE);
  assign in_data   = (state == DATA_ISSUE) || (state == DATA_WAIT);
  assign last_byte = (state == ADDR_WAIT) ? (len == 4'd0) : (idx == len - 4'd1);
  assign rd_byte   = ch ? bus.rd_data1 : bus.rd_data0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= 1'b0;
      last_served <= 1'b1;
      gap_retry   <= 1'b0;
      len         <= '0;
      idx         <= '0;
      retry_cnt   <= '0;
      gap_cnt     <= '0;
      grant       <= '0;
      done        <= '0;
      fail        <= '0;
    end else begin
      done <= '0;
      fail <= '0;
      unique case (state)
        IDLE: if (bus.req0 || bus.req1) begin
          ch        <= pick;
          grant     <= pick ? 2'b10 : 2'b01;
          len       <= pick ? bus.len1 : bus.len0;
          idx       <= '0;
          retry_cnt <= '0;
          state     <= ADDR_ISSUE;
        end
        ADDR_ISSUE: if (!bus.eng_busy) state <= ADDR_WAIT;
        DATA_ISSUE: if (!bus.eng_busy) state <= DATA_WAIT;
        ADDR_WAIT, DATA_WAIT: if (bus.eng_done) begin
          if (bus.eng_ack && !last_byte) begin
            if (state == DATA_WAIT) idx <= idx + 4'd1;
            state <= DATA_ISSUE;
          end else if (!bus.eng_ack && retry_cnt != RW'(MAX_RETRY - 1)) begin
            // Engine already sent STOP; restart from the address byte after the gap.
            retry_cnt <= retry_cnt + 1'b1;
            idx       <= '0;
            gap_retry <= 1'b1;
            gap_cnt   <= '0;
            state     <= GAP;
          end else begin
            done[ch]    <= bus.eng_ack;
            fail[ch]    <= ~bus.eng_ack;
            grant       <= '0;
            last_served <= ch;
            idx         <= '0;
            gap_retry   <= 1'b0;
            gap_cnt     <= '0;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= gap_retry ? ADDR_ISSUE : IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.eng_start      = issue && !bus.eng_busy;
  assign bus.eng_byte       = (state == ADDR_ISSUE) ? {SLAVE_ADDR, 1'b0} :
                              (state == DATA_ISSUE) ? rd_byte : 8'h00;
  assign bus.eng_start_cond = (state == ADDR_ISSUE);
  assign bus.eng_stop_cond  = ((state == ADDR_ISSUE) && (len == 4'd0)) ||
                              ((state == DATA_ISSUE) && (idx == len - 4'd1));
  assign bus.rd_idx         = in_data ? idx : 4'd0;
  assign bus.busy           = (state != IDLE);
  assign bus.grant0         = grant[0];
  assign bus.grant1         = grant[1];
  assign bus.done0          = done[0];
  assign bus.done1          = done[1];
  assign bus.fail0          = fail[0];
  assign bus.fail1          = fail[1];
endmodule

// File: tb/tb_team_06_i2c_sched.sv
// Bench: transaction-level reference model checked every cycle, plus directed
// scenarios with hand-computed expectations and a randomized soak.
module tb_team_06_i2c_sched;
  localparam int GAP  = 16;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  team_06_i2c_sched_if bus();
  team_06_i2c_sched #(.SLAVE_ADDR(7'h27), .MAX_RETRY(MAXR), .GAP_CYCLES(GAP))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] buf0 [16];
  logic [7:0] buf1 [16];
  assign bus.rd_data0 = buf0[bus.rd_idx];
  assign bus.rd_data1 = buf1[bus.rd_idx];

  typedef struct { int cyc; logic [7:0] b; logic sc; logic pc; logic g0; } st_t;
  typedef struct { int cyc; int ch; bit is_fail; } dn_t;
  st_t slog[$];
  dn_t dlog[$];
  int  glog[$];
  int  gcyc[$];
  bit  busy_at[int];

  int errors = 0, checks = 0, cyc = 0;

  // stimulus shadows, applied just after each rising edge
  logic       s_rst = 1'b1, s_req0 = 1'b0, s_req1 = 1'b0;
  logic [3:0] s_len0 = '0, s_len1 = '0;
  int  eng_mode = 0, lat_fix = 2, busy_pct = 0, force_busy = 0, addr_cnt = 0, nack_n = 0;
  int  eng_lat = 0, raise_pct = 0;
  bit  eng_pend = 0, eng_ack_next = 0, auto_req = 0;

  // reference model: who owns the engine, bytes acked this attempt, gap remaining
  int m_owner, m_len, m_sent, m_att, m_gap, m_last;
  bit m_out;
  bit [1:0] m_pd, m_pf;

  task automatic m_reset();
    m_owner = -1; m_len = 0; m_sent = 0; m_att = 0; m_gap = 0; m_last = 1;
    m_out = 0; m_pd = '0; m_pf = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    rst      = s_rst;
    bus.req0 = s_req0; bus.req1 = s_req1;
    bus.len0 = s_len0; bus.len1 = s_len1;
    bus.eng_done = 1'b0;
    bus.eng_ack  = 1'b0;
    if (eng_pend) begin
      eng_lat--;
      if (eng_lat <= 0) begin
        bus.eng_done = 1'b1;
        bus.eng_ack  = eng_ack_next;
        eng_pend     = 0;
      end
    end
    if (force_busy > 0) begin
      bus.eng_busy = 1'b1;
      force_busy--;
    end else bus.eng_busy = ($urandom_range(99) < busy_pct);
  endtask

  task automatic m_finish(input bit ok);
    if (ok) m_pd[m_owner] = 1'b1; else m_pf[m_owner] = 1'b1;
    m_last = m_owner; m_owner = -1; m_gap = GAP; m_sent = 0;
  endtask

  task automatic check_update();
    bit issuing, exp_start;
    int exp_rd, pick;
    logic [7:0] eb;
    busy_at[cyc] = bus.busy;
    if (rst) begin
      chk("rst_grant0", bus.grant0, 0); chk("rst_grant1", bus.grant1, 0);
      chk("rst_done0", bus.done0, 0);   chk("rst_done1", bus.done1, 0);
      chk("rst_fail0", bus.fail0, 0);   chk("rst_fail1", bus.fail1, 0);
      chk("rst_start", bus.eng_start, 0); chk("rst_byte", bus.eng_byte, 0);
      chk("rst_sc", bus.eng_start_cond, 0); chk("rst_pc", bus.eng_stop_cond, 0);
      chk("rst_rdidx", bus.rd_idx, 0);  chk("rst_busy", bus.busy, 0);
      m_reset();
      eng_pend = 0;
      return;
    end
    issuing   = (m_owner >= 0) && (m_gap == 0) && !m_out;
    exp_start = issuing && !bus.eng_busy;
    exp_rd    = (m_owner >= 0 && m_gap == 0 && m_sent > 0) ? m_sent - 1 : 0;
    chk("grant0", bus.grant0, m_owner == 0);
    chk("grant1", bus.grant1, m_owner == 1);
    chk("busy", bus.busy, (m_owner >= 0) || (m_gap > 0));
    chk("eng_start", bus.eng_start, exp_start);
    chk("rd_idx", bus.rd_idx, exp_rd);
    chk("done0", bus.done0, m_pd[0]); chk("done1", bus.done1, m_pd[1]);
    chk("fail0", bus.fail0, m_pf[0]); chk("fail1", bus.fail1, m_pf[1]);
    if (exp_start && bus.eng_start) begin
      eb = (m_sent == 0) ? 8'h4E : (m_owner == 1 ? buf1[m_sent-1] : buf0[m_sent-1]);
      chk("eng_byte", bus.eng_byte, eb);
      chk("start_cond", bus.eng_start_cond, m_sent == 0);
      chk("stop_cond", bus.eng_stop_cond, m_sent == m_len);
    end
    // observation logs and engine/requester reactions
    if (bus.done0 || bus.fail0) begin dlog.push_back('{cyc, 0, bus.fail0}); s_req0 = 1'b0; end
    if (bus.done1 || bus.fail1) begin dlog.push_back('{cyc, 1, bus.fail1}); s_req1 = 1'b0; end
    if (bus.eng_start) begin
      slog.push_back('{cyc, bus.eng_byte, bus.eng_start_cond, bus.eng_stop_cond, bus.grant0});
      eng_pend = 1;
      eng_lat  = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      case (eng_mode)
        0: eng_ack_next = 1;
        1: begin
          eng_ack_next = bus.eng_start_cond ? (addr_cnt >= nack_n) : 1'b1;
          if (bus.eng_start_cond) addr_cnt++;
        end
        2: eng_ack_next = bus.eng_start_cond;
        default: eng_ack_next = ($urandom_range(99) >= 15);
      endcase
    end
    // model step for the coming edge
    m_pd = '0; m_pf = '0;
    if (m_gap > 0) m_gap--;
    else if (m_owner < 0) begin
      if (bus.req0 || bus.req1) begin
        pick = (bus.req0 && bus.req1) ? 1 - m_last : (bus.req1 ? 1 : 0);
        m_owner = pick; m_len = pick ? int'(bus.len1) : int'(bus.len0);
        m_sent = 0; m_att = 1; m_out = 0;
        glog.push_back(pick); gcyc.push_back(cyc + 1);
      end
    end else if (!m_out) begin
      if (exp_start) m_out = 1;
    end else if (bus.eng_done) begin
      m_out = 0;
      if (bus.eng_ack) begin
        if (m_sent == m_len) m_finish(1); else m_sent++;
      end else if (m_att < MAXR) begin
        m_att++; m_sent = 0; m_gap = GAP;
      end else m_finish(0);
    end
    if (auto_req) begin
      if (!s_req0 && m_owner != 0 && $urandom_range(99) < raise_pct) begin
        foreach (buf0[i]) buf0[i] = 8'($urandom);
        s_len0 = 4'($urandom_range(0, 15)); s_req0 = 1'b1;
      end
      if (!s_req1 && m_owner != 1 && $urandom_range(99) < raise_pct) begin
        foreach (buf1[i]) buf1[i] = 8'($urandom);
        s_len1 = 4'($urandom_range(0, 15)); s_req1 = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1 drive();
    @(negedge clk);
    check_update();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_logs();
    slog.delete(); dlog.delete(); glog.delete(); gcyc.delete();
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    run(3);
    s_rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_until_done(input int ch, input int budget, input string nm);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      foreach (dlog[k]) if (dlog[k].ch == ch) found = 1;
    end
    chk(nm, found, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    foreach (buf0[i]) begin buf0[i] = '0; buf1[i] = '0; end
    bus.req0 = 0; bus.req1 = 0; bus.len0 = 0; bus.len1 = 0;
    bus.eng_busy = 0; bus.eng_done = 0; bus.eng_ack = 0;

    // single write, len 2
    do_reset();
    eng_mode = 0; lat_fix = 2; busy_pct = 0;
    buf0[0] = 8'hA5; buf0[1] = 8'h3C; s_len0 = 4'd2; s_req0 = 1'b1;
    run(60);
    chk("t1_nstart", slog.size(), 3);
    if (slog.size() == 3) begin
      chk("t1_b0", slog[0].b, 8'h4E); chk("t1_sc0", slog[0].sc, 1); chk("t1_pc0", slog[0].pc, 0);
      chk("t1_b1", slog[1].b, 8'hA5); chk("t1_pc1", slog[1].pc, 0);
      chk("t1_b2", slog[2].b, 8'h3C); chk("t1_pc2", slog[2].pc, 1);
    end
    chk("t1_ndone", dlog.size(), 1);
    if (dlog.size() == 1) begin
      chk("t1_done_ch", dlog[0].ch, 0); chk("t1_not_fail", dlog[0].is_fail, 0);
      if (slog.size() == 3) chk("t1_done_lat", dlog[0].cyc - slog[2].cyc, 3);
    end

    // tie from reset, then round-robin
    s_len0 = 4'd1; s_len1 = 4'd1; buf0[0] = 8'h11; buf1[0] = 8'h22;
    s_req0 = 1'b1; s_req1 = 1'b1;
    do_reset();
    run_until_done(1, 300, "t2_ch1_done_seen");
    s_req0 = 1'b1; s_req1 = 1'b1;
    run(150);
    chk("t2_ngrants", glog.size() >= 3, 1);
    if (glog.size() >= 3) begin
      chk("t2_g0", glog[0], 0); chk("t2_g1", glog[1], 1); chk("t2_g2", glog[2], 0);
    end
    run(100);

    // address NACK twice, then ACK
    do_reset();
    eng_mode = 1; nack_n = 2; addr_cnt = 0; lat_fix = 2;
    buf0[0] = 8'h5A; s_len0 = 4'd1; s_req0 = 1'b1;
    run(100);
    chk("t3_nstart", slog.size(), 4);
    if (slog.size() == 4) begin
      chk("t3_b0", slog[0].b, 8'h4E); chk("t3_b1", slog[1].b, 8'h4E);
      chk("t3_b2", slog[2].b, 8'h4E); chk("t3_b3", slog[3].b, 8'h5A);
      chk("t3_sp1", slog[1].cyc - slog[0].cyc, 19);
      chk("t3_sp2", slog[2].cyc - slog[1].cyc, 19);
      chk("t3_data", slog[3].cyc - slog[2].cyc, 3);
      foreach (slog[k]) chk("t3_grant0_held", slog[k].g0, 1);
    end
    chk("t3_ndone", dlog.size(), 1);
    if (dlog.size() == 1) chk("t3_ok", dlog[0].is_fail, 0);

    // data byte always NACKed: exhaustion
    do_reset();
    eng_mode = 2; lat_fix = 2;
    buf0[0] = 8'h77; s_len0 = 4'd1; s_req0 = 1'b1;
    run(120);
    chk("t4_nstart", slog.size(), 6);
    chk("t4_ndone", dlog.size(), 1);
    if (dlog.size() == 1) begin
      chk("t4_fail", dlog[0].is_fail, 1); chk("t4_ch", dlog[0].ch, 0);
      chk("t4_busy_last_gap", busy_at[dlog[0].cyc + GAP - 1], 1);
      chk("t4_idle_after_gap", busy_at[dlog[0].cyc + GAP], 0);
    end

    // probe with backpressure
    do_reset();
    eng_mode = 0; lat_fix = 2;
    s_len1 = 4'd0; s_req1 = 1'b1; force_busy = 6;
    run(60);
    chk("t5_nstart", slog.size(), 1);
    if (slog.size() == 1 && gcyc.size() >= 1) begin
      chk("t5_delay", slog[0].cyc - gcyc[0], 5);
      chk("t5_sc", slog[0].sc, 1); chk("t5_pc", slog[0].pc, 1); chk("t5_b", slog[0].b, 8'h4E);
    end
    chk("t5_ndone", dlog.size(), 1);
    if (dlog.size() == 1) begin chk("t5_ch", dlog[0].ch, 1); chk("t5_ok", dlog[0].is_fail, 0); end

    // reset during DATA_WAIT
    do_reset();
    lat_fix = 4;
    foreach (buf1[i]) buf1[i] = 8'(i * 3 + 1);
    s_len1 = 4'd3; s_req1 = 1'b1;
    begin
      bit got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        cycle();
        got = (slog.size() == 2);
      end
      chk("t6_reached_data", got, 1);
    end
    s_rst = 1'b1;
    run(2);
    chk("t6_no_pulse", dlog.size(), 0);
    s_len1 = 4'd1;
    s_rst = 1'b0;
    clear_logs();
    run(60);
    chk("t6_nstart", slog.size(), 2);
    chk("t6_ndone", dlog.size(), 1);
    if (dlog.size() == 1) begin chk("t6_ch", dlog[0].ch, 1); chk("t6_ok", dlog[0].is_fail, 0); end

    // randomized soak
    do_reset();
    eng_mode = 3; lat_fix = 0; busy_pct = 30; raise_pct = 10; auto_req = 1;
    run(3000);
    auto_req = 0;
    run(900);
    chk("soak_some_done", dlog.size() > 0, 1);
    chk("soak_drained", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/team_06_i2c_sched.md
# team_06_i2c_sched

Transaction scheduler that shares the single I2C byte engine between two requesters: channel 0, effect updates, and channel 1, LCD data/text writes. It arbitrates round-robin and frames each write transaction as address byte plus up to 15 data bytes. It drives the engine one byte at a time, restarts the transaction on NACK up to a retry limit, and enforces an idle gap between transactions. It sits between the effect/display logic and the I2C engine.

## Interface
- SLAVE_ADDR, 7'h27, 7-bit LCD slave address; the address byte sent is {SLAVE_ADDR,1'b0}
- MAX_RETRY, 3, total attempts per transaction before failing (≥1)
- GAP_CYCLES, 16, clk cycles spent in GAP after every attempt (≥1)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  request level; held high until done/fail of that channel
- len0 / len1  in  4  data byte count (0 = address-only probe); sampled at grant
- rd_data0 / rd_data1  in  8  byte at rd_idx from the requester's buffer (combinational read)
- grant0 / grant1  out  1  channel owns engine; high from grant through the done/fail cycle's predecessor
- done0 / done1  out  1  one-cycle pulse: transaction completed with all ACKs
- fail0 / fail1  out  1  one-cycle pulse: MAX_RETRY attempts NACKed
- rd_idx  out  4  index of byte being fetched from the granted channel
- eng_start  out  1  one-cycle byte launch to engine
- eng_byte  out  8  byte to send; valid with eng_start
- eng_start_cond  out  1  engine precedes byte with START; valid with eng_start
- eng_stop_cond  out  1  engine follows byte with STOP; valid with eng_start
- eng_busy  in  1  engine not ready to accept eng_start
- eng_done  in  1  one-cycle pulse: byte and ACK slot finished
- eng_ack  in  1  ACK result, valid with eng_done (1 = ACK). On NACK the engine issues STOP itself.
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ADDR_ISSUE, ADDR_WAIT, DATA_ISSUE, DATA_WAIT, GAP.
- IDLE arbitration: one channel requesting wins. With both requesting, the winner is the channel not served last. The last_served register resets to 1, so channel 0 wins the first tie. On grant: latch len and channel, clear idx and retry_cnt, go to ADDR_ISSUE.
- ISSUE states: eng_start = state is ISSUE && !eng_busy (Moore/comb). The state advances to the matching WAIT on the same condition.
- ADDR_ISSUE: eng_byte={SLAVE_ADDR,0}, eng_start_cond=1, eng_stop_cond=(len==0).
- DATA_ISSUE: eng_byte=rd_data of granted channel at rd_idx, start_cond=0, stop_cond=(idx==len-1).
- WAIT states: eng_done is ignored outside WAIT states.
  - eng_done with eng_ack=1 from ADDR_WAIT: go to DATA_ISSUE if len≠0, else success.
  - eng_done with eng_ack=1 from DATA_WAIT: idx+1 (4-bit, never wraps since idx<len≤15); go to DATA_ISSUE if idx≠len-1, else success.
  - eng_done with eng_ack=0 from either WAIT: retry_cnt+1. If retry_cnt+1 < MAX_RETRY, go to GAP then ADDR_ISSUE with idx=0, rd_idx=0, channel kept, grant kept. Otherwise fail.
- Success: done pulse on the granted channel, grant drops, last_served updated, go to GAP then IDLE.
- Fail: fail pulse on the granted channel, grant drops, last_served updated, go to GAP then IDLE.
- rd_idx mirrors idx; it is held at 0 outside the DATA states.
- Requests dropped mid-transaction are ignored; the transaction completes on latched len.
- The second channel's request waits; no preemption.

## Timing
- Reset: all outputs 0, state IDLE, idx/retry/gap counters 0, last_served=1. Reset mid-transaction aborts immediately with no done/fail pulse.
- IDLE:
  - req seen at edge N → grant high and state ADDR_ISSUE from cycle N+1.
  - eng_start is asserted in cycle N+1 if eng_busy=0.
- eng_start is exactly one cycle per ISSUE visit. While eng_busy=1, the FSM stays in ISSUE with eng_start=0.
- eng_done at cycle M in a WAIT state → next ISSUE state at M+1, so eng_start at M+1 if not busy.
- Final eng_done at M:
  - done/fail pulse in cycle M+1 (registered), grant low at M+1.
  - GAP occupies cycles M+1..M+GAP_CYCLES.
  - IDLE at M+GAP_CYCLES+1; the next grant comes at earliest M+GAP_CYCLES+2.
- Retry: NACK eng_done at M → GAP M+1..M+GAP_CYCLES, ADDR_ISSUE at M+GAP_CYCLES+1, grant held high throughout.
- Bytes per transaction = len+1; eng_start count on success = len+1.

## Test plan
- Single write: req0=1, len0=2, buffer {8'hA5,8'h3C}, engine ACKs all → eng_byte sequence 8'h4E(start),8'hA5,8'h3C(stop); done0 one pulse; fail0 never high.
- Tie and round-robin: req0 and req1 both high from reset, len=1 each → channel 0 served first, then channel 1; with req0 re-raised during channel 1's GAP, channel 0 is served next.
- NACK retry: len0=1, engine NACKs the address on attempts 1–2 and ACKs on 3 → three ADDR starts spaced by GAP_CYCLES, then the data byte; done0 pulse; grant0 stays high across the retries.
- Retry exhaustion: engine always NACKs the data byte → exactly 3 attempts, fail0 pulse, no done0; IDLE after GAP_CYCLES.
- Probe and backpressure: len1=0 with eng_busy held high 5 cycles → eng_start delayed 5 cycles; a single byte with start_cond=1 and stop_cond=1; done1 pulse.
- Reset mid-DATA_WAIT: rst asserted → all outputs 0 the same cycle; no done/fail pulse; after release a new req1 is granted normally.
